ball_kinematics_engine: RTL and testbench

Parametrised fixed-point 2-D motion engine for the game ball. Sits in the VGA object path between the collision detector/keyboard logic and the ball bitmap drawer. Position advances once per frame. Beyond the current ball mover it adds:
- reflection per edge, corners included;
- a trap/charge/kick state machine;
- a post-hit cooldown against repeated bounces;
- saturating speed arithmetic;
- configurable fraction bits and friction.

---
 rtl/ball_kinematics_engine.sv | 209 ++++++++++++++++++++
 tb/tb_ball_kinematics_engine.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_kinematics_engine.sv
// Fixed-point 2-D ball mover: per-frame position advance, edge reflection,
// trap/charge/kick control, post-hit cooldown and periodic friction.
module ball_kinematics_engine #(
    parameter int FRAC_BITS       = 6,
    parameter int POS_W           = 11,
    parameter int SPD_W           = 11,
    parameter int MAX_SPEED       = 300,
    parameter int INIT_X          = 280,
    parameter int INIT_Y          = 185,
    parameter int INIT_VX         = 150,
    parameter int INIT_VY         = 150,
    parameter int SERVE_X         = 320,
    parameter int SERVE_Y         = 224,
    parameter int SERVE_VX        = 160,
    parameter int SERVE_VY        = 150,
    parameter int FRICTION_PERIOD = 30,
    parameter int FRICTION_STEP   = 1,
    parameter int CHARGE_STEP     = 1,
    parameter int CHARGE_MAX      = 200,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic [3:0]              HitEdgeCode,
    input  logic                    playerHit,
    input  logic                    kickCharge,
    input  logic                    kickRelease,
    input  logic                    kickDirX,
    input  logic [1:0]              kickAim,
    input  logic                    serveReq,
    output logic signed [POS_W-1:0] topLeftX,
    output logic signed [POS_W-1:0] topLeftY,
    output logic signed [SPD_W-1:0] speedX,
    output logic signed [SPD_W-1:0] speedY,
    output logic [7:0]              kickLevel,
    output logic [1:0]              state
);

    localparam int PW = POS_W + FRAC_BITS + 1;
    localparam int VW = SPD_W + 10;
    localparam int FW = $clog2(FRICTION_PERIOD + 1);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic signed [PW:0]   POS_HI = {3'b000, {(POS_W + FRAC_BITS - 1){1'b1}}};
    localparam logic signed [PW:0]   POS_LO = {3'b111, {(POS_W + FRAC_BITS - 1){1'b0}}};
    localparam logic signed [VW-1:0] V_MAX  = VW'(MAX_SPEED);
    localparam logic signed [VW-1:0] F_STEP = VW'(FRICTION_STEP);

    typedef enum logic [1:0] {MOVING = 2'd0, HOLD = 2'd1, COOLDOWN = 2'd2} state_t;

    state_t                  state_q, state_n;
    logic signed [PW-1:0]    pos_x, pos_y, pos_x_n, pos_y_n;
    logic signed [SPD_W-1:0] vx, vy, vx_n, vy_n;
    logic [7:0]              charge, charge_n;
    logic [CW-1:0]           cool, cool_n;
    logic [FW-1:0]           fric_cnt, fric_n;
    logic                    frame_adv, wrap, rx, ry, kick, bounce;
    logic signed [VW-1:0]    kmag_x, kmag_y;

    function automatic logic signed [VW-1:0] wide(input logic signed [SPD_W-1:0] v);
        return {{(VW - SPD_W){v[SPD_W-1]}}, v};
    endfunction

    function automatic logic signed [SPD_W-1:0] sat_v(input logic signed [VW-1:0] v);
        if (v > V_MAX)       return SPD_W'(MAX_SPEED);
        else if (v < -V_MAX) return SPD_W'(-MAX_SPEED);
        else                 return v[SPD_W-1:0];
    endfunction

    function automatic logic signed [SPD_W-1:0] neg_v(input logic signed [SPD_W-1:0] v);
        return sat_v(-wide(v));
    endfunction

    function automatic logic signed [VW-1:0] abs_v(input logic signed [SPD_W-1:0] v);
        return (v < 0) ? -wide(v) : wide(v);
    endfunction

    // Moves toward zero but never crosses it.
    function automatic logic signed [SPD_W-1:0] fric_v(input logic signed [SPD_W-1:0] v);
        if (wide(v) > F_STEP)       return v - SPD_W'(FRICTION_STEP);
        else if (wide(v) < -F_STEP) return v + SPD_W'(FRICTION_STEP);
        else                        return '0;
    endfunction

    function automatic logic signed [PW-1:0] add_p(input logic signed [PW-1:0] p,
                                                   input logic signed [SPD_W-1:0] v);
        logic signed [PW:0] s;
        s = {p[PW-1], p} + {{(PW + 1 - SPD_W){v[SPD_W-1]}}, v};
        if (s > POS_HI)      return POS_HI[PW-1:0];
        else if (s < POS_LO) return POS_LO[PW-1:0];
        else                 return s[PW-1:0];
    endfunction

    function automatic logic [7:0] charge_add(input logic [7:0] c);
        logic [8:0] s;
        s = {1'b0, c} + 9'(CHARGE_STEP);
        return (s > 9'(CHARGE_MAX)) ? 8'(CHARGE_MAX) : s[7:0];
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pos_x    <= PW'(INIT_X * (2 ** FRAC_BITS));
            pos_y    <= PW'(INIT_Y * (2 ** FRAC_BITS));
            vx       <= sat_v(VW'(INIT_VX));
            vy       <= sat_v(VW'(INIT_VY));
            charge   <= '0;
            cool     <= '0;
            fric_cnt <= '0;
            state_q  <= MOVING;
        end else begin
            pos_x    <= pos_x_n;
            pos_y    <= pos_y_n;
            vx       <= vx_n;
            vy       <= vy_n;
            charge   <= charge_n;
            cool     <= cool_n;
            fric_cnt <= fric_n;
            state_q  <= state_n;
        end
    end

    always_comb begin
        pos_x_n   = pos_x;
        pos_y_n   = pos_y;
        vx_n      = vx;
        vy_n      = vy;
        charge_n  = charge;
        cool_n    = cool;
        fric_n    = fric_cnt;
        state_n   = state_q;
        kick      = 1'b0;
        bounce    = 1'b0;
        kmag_x    = abs_v(vx) + $signed({{(VW - 8){1'b0}}, charge});
        kmag_y    = abs_v(vy) + $signed({{(VW - 8){1'b0}}, charge});
        frame_adv = startOfFrame && (state_q != HOLD);
        wrap      = frame_adv && (fric_cnt == FW'(FRICTION_PERIOD - 1));
        rx        = (HitEdgeCode[1] && vx > 0) || (HitEdgeCode[3] && vx < 0);
        ry        = (HitEdgeCode[2] && vy < 0) || (HitEdgeCode[0] && vy > 0);

        if (frame_adv) begin
            pos_x_n = add_p(pos_x, vx);
            pos_y_n = add_p(pos_y, vy);
            fric_n  = wrap ? '0 : fric_cnt + 1'b1;
        end
        if (state_q == COOLDOWN && startOfFrame) begin
            if (cool == CW'(COOLDOWN_FRAMES - 1)) begin
                state_n = MOVING;
                cool_n  = '0;
            end else begin
                cool_n = cool + 1'b1;
            end
        end
        if (state_q == HOLD && kickCharge && startOfFrame)
            charge_n = charge_add(charge);

        // An edge reflection pre-empts every player rule in the same cycle.
        if (rx || ry) begin
            if (rx) vx_n = neg_v(vx);
            if (ry) vy_n = neg_v(vy);
        end else if (state_q == HOLD) begin
            if (kickRelease) begin
                kick     = 1'b1;
                vx_n     = sat_v(kickDirX ? kmag_x : -kmag_x);
                if (kickAim == 2'b01)      vy_n = sat_v(-kmag_y);
                else if (kickAim == 2'b10) vy_n = sat_v(kmag_y);
                charge_n = '0;
                cool_n   = '0;
                state_n  = COOLDOWN;
            end else if (!playerHit) begin
                charge_n = '0;
                state_n  = MOVING;
            end
        end else if (state_q == MOVING && playerHit) begin
            if (kickCharge) begin
                state_n = HOLD;
            end else begin
                bounce  = 1'b1;
                vx_n    = neg_v(vx);
                vy_n    = neg_v(vy);
                cool_n  = '0;
                state_n = COOLDOWN;
            end
        end

        if (wrap && !(rx || ry || kick || bounce)) begin
            vx_n = fric_v(vx);
            vy_n = fric_v(vy);
        end

        if (serveReq) begin
            pos_x_n  = PW'(SERVE_X * (2 ** FRAC_BITS));
            pos_y_n  = PW'(SERVE_Y * (2 ** FRAC_BITS));
            vx_n     = sat_v(VW'(SERVE_VX));
            vy_n     = sat_v(VW'(SERVE_VY));
            charge_n = '0;
            cool_n   = '0;
            fric_n   = '0;
            state_n  = MOVING;
        end
    end

    assign topLeftX  = POS_W'(pos_x >>> FRAC_BITS);
    assign topLeftY  = POS_W'(pos_y >>> FRAC_BITS);
    assign speedX    = vx;
    assign speedY    = vy;
    assign kickLevel = charge;
    assign state     = state_q;

endmodule

// File: tb/tb_ball_kinematics_engine.sv
// Self-checking bench for ball_kinematics_engine: directed scenarios plus
// randomized stimulus tracked by an integer reference model.
module tb_ball_kinematics_engine;

    localparam int FB   = 6;
    localparam int PXW  = 11;
    localparam int MAXS = 300;
    localparam int FP   = 30;
    localparam int FS   = 1;
    localparam int CS   = 1;
    localparam int CM   = 200;
    localparam int CD   = 8;
    localparam int PHI  = (1 << (PXW - 1 + FB)) - 1;
    localparam int PLO  = -(1 << (PXW - 1 + FB));

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic sof = 1'b0, sof2 = 1'b0, ph = 1'b0, kc = 1'b0, kr = 1'b0, kdir = 1'b0, serve = 1'b0;
    logic [3:0] edge_code = '0;
    logic [1:0] aim = '0;
    logic signed [10:0] tlx, tly, spx, spy, tlx2, tly2, spx2, spy2;
    logic [7:0] lvl, lvl2;
    logic [1:0] st, st2;

    int n_checks = 0;
    int n_err = 0;

    // reference model state: position in 1/64 pixel, state 0/1/2
    int m_x, m_y, m_vx, m_vy, m_lvl, m_cool, m_fric, m_st;

    always #5 clk = ~clk;

    ball_kinematics_engine dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .HitEdgeCode(edge_code),
        .playerHit(ph), .kickCharge(kc), .kickRelease(kr), .kickDirX(kdir),
        .kickAim(aim), .serveReq(serve), .topLeftX(tlx), .topLeftY(tly),
        .speedX(spx), .speedY(spy), .kickLevel(lvl), .state(st)
    );

    ball_kinematics_engine #(.INIT_VX(1), .INIT_VY(-1), .FRICTION_PERIOD(4)) dut2 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof2), .HitEdgeCode(4'b0000),
        .playerHit(1'b0), .kickCharge(1'b0), .kickRelease(1'b0), .kickDirX(1'b0),
        .kickAim(2'b00), .serveReq(1'b0), .topLeftX(tlx2), .topLeftY(tly2),
        .speedX(spx2), .speedY(spy2), .kickLevel(lvl2), .state(st2)
    );

    function automatic int clampv(int v);
        return (v > MAXS) ? MAXS : (v < -MAXS) ? -MAXS : v;
    endfunction

    function automatic int clampp(int p);
        return (p > PHI) ? PHI : (p < PLO) ? PLO : p;
    endfunction

    function automatic int toward_zero(int v);
        if (v > FS)  return v - FS;
        if (v < -FS) return v + FS;
        return 0;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_x = 280 * 64; m_y = 185 * 64; m_vx = 150; m_vy = 150;
        m_lvl = 0; m_cool = 0; m_fric = 0; m_st = 0;
    endtask

    task automatic model_step();
        int nx, ny, nvx, nvy, nlvl, ncool, nfric, nst;
        bit wrapped, evt, rx, ry;
        nx = m_x; ny = m_y; nvx = m_vx; nvy = m_vy;
        nlvl = m_lvl; ncool = m_cool; nfric = m_fric; nst = m_st;
        wrapped = 0; evt = 0;
        if (serve) begin
            nx = 320 * 64; ny = 224 * 64; nvx = 160; nvy = 150;
            nlvl = 0; ncool = 0; nfric = 0; nst = 0;
        end else begin
            if (sof && m_st != 1) begin
                nx = clampp(m_x + m_vx);
                ny = clampp(m_y + m_vy);
                nfric = (m_fric + 1) % FP;
                wrapped = (nfric == 0);
            end
            if (m_st == 2 && sof) begin
                ncool = m_cool + 1;
                if (ncool == CD) begin nst = 0; ncool = 0; end
            end
            if (m_st == 1 && kc && sof) nlvl = (m_lvl + CS > CM) ? CM : m_lvl + CS;
            rx = (edge_code[1] && m_vx > 0) || (edge_code[3] && m_vx < 0);
            ry = (edge_code[2] && m_vy < 0) || (edge_code[0] && m_vy > 0);
            if (rx || ry) begin
                evt = 1;
                if (rx) nvx = clampv(-m_vx);
                if (ry) nvy = clampv(-m_vy);
            end else if (m_st == 1) begin
                if (kr) begin
                    evt = 1;
                    nvx = clampv(kdir ? iabs(m_vx) + m_lvl : -(iabs(m_vx) + m_lvl));
                    if (aim == 2'b01) nvy = clampv(-(iabs(m_vy) + m_lvl));
                    if (aim == 2'b10) nvy = clampv(iabs(m_vy) + m_lvl);
                    nlvl = 0; ncool = 0; nst = 2;
                end else if (!ph) begin
                    nlvl = 0; nst = 0;
                end
            end else if (m_st == 0 && ph) begin
                if (kc) nst = 1;
                else begin
                    evt = 1; nvx = clampv(-m_vx); nvy = clampv(-m_vy); ncool = 0; nst = 2;
                end
            end
            if (wrapped && !evt) begin
                nvx = toward_zero(nvx);
                nvy = toward_zero(nvy);
            end
        end
        m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy;
        m_lvl = nlvl; m_cool = ncool; m_fric = nfric; m_st = nst;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sof = 0; sof2 = 0; ph = 0; kc = 0; kr = 0; kdir = 0; serve = 0;
        edge_code = '0; aim = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        resetN = 0;
        @(posedge clk);
        #1;
        resetN = 1;
        model_reset();
    endtask

    task automatic frame();
        sof = 1; tick(); sof = 0; tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (tlx !== 11'sd280) begin n_err++; $display("FAIL reset_x: got %0d expected 280", tlx); end
        n_checks++; if (tly !== 11'sd185) begin n_err++; $display("FAIL reset_y: got %0d expected 185", tly); end
        n_checks++; if (spx !== 11'sd150) begin n_err++; $display("FAIL reset_vx: got %0d expected 150", spx); end
        n_checks++; if (spy !== 11'sd150) begin n_err++; $display("FAIL reset_vy: got %0d expected 150", spy); end
        n_checks++; if (lvl !== 8'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", lvl); end
        n_checks++; if (st !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", st); end
    endtask

    task automatic test_first_frame();
        apply_reset();
        sof = 1; tick(); sof = 0;
        n_checks++; if (tlx !== 11'sd282) begin n_err++; $display("FAIL frame1_x: got %0d expected 282", tlx); end
        n_checks++; if (tly !== 11'sd187) begin n_err++; $display("FAIL frame1_y: got %0d expected 187", tly); end
        n_checks++; if (spx !== 11'sd150) begin n_err++; $display("FAIL frame1_vx: got %0d expected 150", spx); end
    endtask

    task automatic test_friction();
        apply_reset();
        for (int i = 0; i < 29; i++) frame();
        n_checks++; if (spx !== 11'sd150) begin n_err++; $display("FAIL friction_29_vx: got %0d expected 150", spx); end
        frame();
        n_checks++; if (spx !== 11'sd149) begin n_err++; $display("FAIL friction_30_vx: got %0d expected 149", spx); end
        n_checks++; if (spy !== 11'sd149) begin n_err++; $display("FAIL friction_30_vy: got %0d expected 149", spy); end
    endtask

    task automatic test_friction_floor();
        apply_reset();
        for (int i = 0; i < 3; i++) begin sof2 = 1; tick(); sof2 = 0; tick(); end
        n_checks++; if (spx2 !== 11'sd1) begin n_err++; $display("FAIL floor_pre_vx: got %0d expected 1", spx2); end
        sof2 = 1; tick(); sof2 = 0;
        n_checks++; if (spx2 !== 11'sd0) begin n_err++; $display("FAIL floor_vx: got %0d expected 0", spx2); end
        n_checks++; if (spy2 !== 11'sd0) begin n_err++; $display("FAIL floor_vy: got %0d expected 0", spy2); end
        for (int i = 0; i < 4; i++) begin sof2 = 1; tick(); sof2 = 0; tick(); end
        n_checks++; if (spx2 !== 11'sd0) begin n_err++; $display("FAIL floor_zero_vx: got %0d expected 0", spx2); end
        n_checks++; if (spy2 !== 11'sd0) begin n_err++; $display("FAIL floor_zero_vy: got %0d expected 0", spy2); end
    endtask

    task automatic test_corner();
        apply_reset();
        edge_code = 4'b0011; tick();
        n_checks++; if (spx !== -11'sd150) begin n_err++; $display("FAIL corner_vx: got %0d expected -150", spx); end
        n_checks++; if (spy !== -11'sd150) begin n_err++; $display("FAIL corner_vy: got %0d expected -150", spy); end
        tick();
        n_checks++; if (spx !== -11'sd150) begin n_err++; $display("FAIL corner_away_vx: got %0d expected -150", spx); end
        n_checks++; if (spy !== -11'sd150) begin n_err++; $display("FAIL corner_away_vy: got %0d expected -150", spy); end
        edge_code = 4'b1100; tick(); edge_code = '0;
        n_checks++; if (spx !== 11'sd150) begin n_err++; $display("FAIL left_top_vx: got %0d expected 150", spx); end
        n_checks++; if (spy !== 11'sd150) begin n_err++; $display("FAIL left_top_vy: got %0d expected 150", spy); end
    endtask

    task automatic test_charged_kick();
        apply_reset();
        ph = 1; kc = 1; tick();
        n_checks++; if (st !== 2'd1) begin n_err++; $display("FAIL hold_enter: got %0d expected 1", st); end
        for (int i = 0; i < 50; i++) frame();
        n_checks++; if (lvl !== 8'd50) begin n_err++; $display("FAIL charge_50: got %0d expected 50", lvl); end
        n_checks++; if (tlx !== 11'sd280) begin n_err++; $display("FAIL hold_frozen_x: got %0d expected 280", tlx); end
        n_checks++; if (tly !== 11'sd185) begin n_err++; $display("FAIL hold_frozen_y: got %0d expected 185", tly); end
        kr = 1; kdir = 0; aim = 2'b01; tick(); kr = 0; ph = 0; kc = 0;
        n_checks++; if (spx !== -11'sd200) begin n_err++; $display("FAIL kick_vx: got %0d expected -200", spx); end
        n_checks++; if (spy !== -11'sd200) begin n_err++; $display("FAIL kick_vy: got %0d expected -200", spy); end
        n_checks++; if (st !== 2'd2) begin n_err++; $display("FAIL kick_state: got %0d expected 2", st); end
        n_checks++; if (lvl !== 8'd0) begin n_err++; $display("FAIL kick_level: got %0d expected 0", lvl); end
    endtask

    task automatic test_kick_saturation_cooldown();
        apply_reset();
        ph = 1; kc = 1; tick();
        for (int i = 0; i < 210; i++) frame();
        n_checks++; if (lvl !== 8'd200) begin n_err++; $display("FAIL charge_cap: got %0d expected 200", lvl); end
        kr = 1; kdir = 1; aim = 2'b00; tick(); kr = 0; kc = 0;
        n_checks++; if (spx !== 11'sd300) begin n_err++; $display("FAIL kick_sat_vx: got %0d expected 300", spx); end
        n_checks++; if (spy !== 11'sd150) begin n_err++; $display("FAIL kick_keep_vy: got %0d expected 150", spy); end
        for (int i = 0; i < 7; i++) frame();
        n_checks++; if (st !== 2'd2) begin n_err++; $display("FAIL cooldown_7_state: got %0d expected 2", st); end
        n_checks++; if (spx !== 11'sd300) begin n_err++; $display("FAIL cooldown_7_vx: got %0d expected 300", spx); end
        sof = 1; tick(); sof = 0;
        n_checks++; if (st !== 2'd0) begin n_err++; $display("FAIL cooldown_8_state: got %0d expected 0", st); end
        n_checks++; if (spx !== 11'sd300) begin n_err++; $display("FAIL cooldown_8_vx: got %0d expected 300", spx); end
        ph = 0;
    endtask

    task automatic test_serve_priority();
        apply_reset();
        ph = 1; kc = 1; tick();
        for (int i = 0; i < 5; i++) frame();
        serve = 1; sof = 1; edge_code = 4'b1111; kr = 1; tick();
        clear_inputs();
        n_checks++; if (tlx !== 11'sd320) begin n_err++; $display("FAIL serve_x: got %0d expected 320", tlx); end
        n_checks++; if (tly !== 11'sd224) begin n_err++; $display("FAIL serve_y: got %0d expected 224", tly); end
        n_checks++; if (spx !== 11'sd160) begin n_err++; $display("FAIL serve_vx: got %0d expected 160", spx); end
        n_checks++; if (spy !== 11'sd150) begin n_err++; $display("FAIL serve_vy: got %0d expected 150", spy); end
        n_checks++; if (st !== 2'd0) begin n_err++; $display("FAIL serve_state: got %0d expected 0", st); end
        n_checks++; if (lvl !== 8'd0) begin n_err++; $display("FAIL serve_level: got %0d expected 0", lvl); end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        ph = 1; kc = 1; tick();
        for (int i = 0; i < 5; i++) frame();
        n_checks++; if (lvl !== 8'd5) begin n_err++; $display("FAIL pre_reset_level: got %0d expected 5", lvl); end
        resetN = 0;
        #2;
        n_checks++; if (st !== 2'd0) begin n_err++; $display("FAIL async_state: got %0d expected 0", st); end
        n_checks++; if (lvl !== 8'd0) begin n_err++; $display("FAIL async_level: got %0d expected 0", lvl); end
        n_checks++; if (tlx !== 11'sd280) begin n_err++; $display("FAIL async_x: got %0d expected 280", tlx); end
        n_checks++; if (spy !== 11'sd150) begin n_err++; $display("FAIL async_vy: got %0d expected 150", spy); end
        clear_inputs();
        @(posedge clk);
        #1;
        resetN = 1;
        model_reset();
    endtask

    task automatic test_pos_saturation();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            sof = 1; tick();
            n_checks++;
            if (tlx !== 11'(m_x >>> FB)) begin n_err++; $display("FAIL sat_track_x: got %0d expected %0d", tlx, m_x >>> FB); end
        end
        sof = 0;
        n_checks++; if (tlx !== 11'sd1023) begin n_err++; $display("FAIL sat_x: got %0d expected 1023", tlx); end
        n_checks++; if (tly !== 11'sd1023) begin n_err++; $display("FAIL sat_y: got %0d expected 1023", tly); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            sof       = ($urandom_range(0, 2) == 0);
            edge_code = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 4) == 0) ph = ~ph;
            if ($urandom_range(0, 5) == 0) kc = ~kc;
            kr        = ($urandom_range(0, 11) == 0);
            kdir      = 1'($urandom);
            aim       = 2'($urandom);
            serve     = ($urandom_range(0, 299) == 0);
            tick();
            n_checks++;
            if (tlx !== 11'(m_x >>> FB) || tly !== 11'(m_y >>> FB)) begin
                n_err++;
                $display("FAIL rand_pos cycle %0d: got %0d,%0d expected %0d,%0d", i, tlx, tly, m_x >>> FB, m_y >>> FB);
            end
            n_checks++;
            if (spx !== 11'(m_vx) || spy !== 11'(m_vy)) begin
                n_err++;
                $display("FAIL rand_speed cycle %0d: got %0d,%0d expected %0d,%0d", i, spx, spy, m_vx, m_vy);
            end
            n_checks++;
            if (lvl !== 8'(m_lvl) || st !== 2'(m_st)) begin
                n_err++;
                $display("FAIL rand_ctrl cycle %0d: got level %0d state %0d expected level %0d state %0d", i, lvl, st, m_lvl, m_st);
            end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_friction();
        test_friction_floor();
        test_corner();
        test_charged_kick();
        test_kick_saturation_cooldown();
        test_serve_priority();
        test_reset_mid_hold();
        test_pos_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
